cic_iq_decimator: RTL and testbench

Parametrised dual-channel (I/Q) CIC decimator that follows the mixer in the receiver chain. It replaces the two fixed single-channel CIC instances with one block that has:
- configurable order and width;
- a decimation ratio set at run time;
- a gain shift with saturation;
- a valid/ready output toward the Hilbert stage and the SPI masters;
- warm-up suppression and sticky error flags.

---
 rtl/cic_iq_decimator_if.sv | 31 +++
 rtl/cic_iq_decimator.sv | 210 +++++++++++++++++++++
 tb/tb_cic_iq_decimator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cic_iq_decimator_if.sv
// Sample/result bus of the dual-channel CIC decimator.
// master: mixer/consumer side, slave: the decimator itself.
interface cic_iq_decimator_if #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 32,
    parameter int DEC_W = 13
) ();
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_i;
    logic signed [IN_W-1:0]  in_q;
    logic [DEC_W-1:0]        dec_ratio;
    logic                    dec_load;
    logic [7:0]              gain_shift;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_i;
    logic signed [OUT_W-1:0] out_q;
    logic                    d_clk;
    logic                    sat_flag;
    logic                    overrun_flag;

    modport master (
        output in_valid, in_i, in_q, dec_ratio, dec_load, gain_shift, out_ready,
        input  out_valid, out_i, out_q, d_clk, sat_flag, overrun_flag
    );

    modport slave (
        input  in_valid, in_i, in_q, dec_ratio, dec_load, gain_shift, out_ready,
        output out_valid, out_i, out_q, d_clk, sat_flag, overrun_flag
    );
endinterface

// File: rtl/cic_iq_decimator.sv
// Dual-channel (I/Q) CIC decimator with run-time ratio, gain window with
// saturation, warm-up suppression and a valid/ready output register.
// Optional build macro: CIC_ROUND_EN (round half up before the bit-window
// select; default build truncates).
module cic_iq_decimator #(
    parameter int IN_W    = 20,
    parameter int OUT_W   = 32,
    parameter int ORDER   = 4,
    parameter int ACC_W   = 80,
    parameter int DEC_MAX = 4096,
    parameter int DEC_W   = 13
) (
    input logic               osc_clk,
    input logic               rst,
    cic_iq_decimator_if.slave bus
);
    localparam int         HEAD      = ACC_W - OUT_W;
    localparam logic [2:0] WARM_DONE = 3'(ORDER);

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t             r_int_i [ORDER];
    acc_t             r_int_q [ORDER];
    acc_t             w_int_nxt_i [ORDER];
    acc_t             w_int_nxt_q [ORDER];
    acc_t             r_cmb_i [ORDER];
    acc_t             r_cmb_q [ORDER];
    acc_t             r_dly_i [ORDER];
    acc_t             r_dly_q [ORDER];
    acc_t             w_cin_i [ORDER];
    acc_t             w_cin_q [ORDER];
    logic [ORDER-1:0] r_cv, r_ck, w_cvin, w_ckin;
    logic [DEC_W-1:0] r_cnt, r_ratio, r_pend, w_clamp;
    logic [2:0]       r_warm;
    logic             r_ev, r_ek, w_wrap, w_load;
    logic [7:0]       w_g;
    int               w_sh;
    logic [OUT_W-1:0] w_o_i, w_o_q;
    logic             w_sat_i, w_sat_q;
    logic signed [OUT_W-1:0] r_out_i, r_out_q;
    logic             r_out_valid, r_dclk, r_sat, r_overrun;

    // Bit-window select of one comb result: arithmetic right shift by sh,
    // optional half-LSB rounding, and saturation when the bits above the
    // window are not all copies of its sign.
    function automatic void scale(input acc_t x, input int sh,
                                  output logic [OUT_W-1:0] val, output logic sat);
        logic signed [ACC_W:0]       v_ext;
        logic signed [ACC_W:0]       v_shd;
        logic [ACC_W-OUT_W+1:0]      v_up;
        v_ext = {x[ACC_W-1], x};
`ifdef CIC_ROUND_EN
        if (sh > 0) v_ext = v_ext + ({{ACC_W{1'b0}}, 1'b1} << (sh - 1));
`endif
        v_shd = v_ext >>> sh;
        v_up  = v_shd[ACC_W:OUT_W-1];
        sat   = !((&v_up) || !(|v_up));
        if (!sat)              val = v_shd[OUT_W-1:0];
        else if (v_ext[ACC_W]) val = {1'b1, {(OUT_W-1){1'b0}}};
        else                   val = {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Next integrator values: the whole cascade settles in the sample's cycle.
    always_comb begin
        acc_t v_acc_i, v_acc_q;
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_int_nxt_i = r_int_i;
        w_int_nxt_q = r_int_q;
        v_acc_i     = {{(ACC_W-IN_W){bus.in_i[IN_W-1]}}, bus.in_i};
        v_acc_q     = {{(ACC_W-IN_W){bus.in_q[IN_W-1]}}, bus.in_q};
        for (int k = 0; k < ORDER; k++) begin
            v_acc_i        = r_int_i[k] + v_acc_i;
            v_acc_q        = r_int_q[k] + v_acc_q;
            w_int_nxt_i[k] = v_acc_i;
            w_int_nxt_q[k] = v_acc_q;
        end
    end

    // Integrator state, advanced on each accepted sample (wraps modulo 2^ACC_W).
    always_ff @(posedge osc_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the filter arrays are reset because the datapath must restart from zero.
            for (int k = 0; k < ORDER; k++) begin
                r_int_i[k] <= '0;
                r_int_q[k] <= '0;
            end
        end else if (bus.in_valid) begin
            r_int_i <= w_int_nxt_i;
            r_int_q <= w_int_nxt_q;
        end
    end

    assign w_wrap = bus.in_valid && (r_cnt == r_ratio - DEC_W'(1));

    // Clamp the requested ratio into 2..DEC_MAX.
    always_comb begin
        w_clamp = bus.dec_ratio;
        if (bus.dec_ratio < DEC_W'(2))            w_clamp = DEC_W'(2);
        else if (bus.dec_ratio > DEC_W'(DEC_MAX)) w_clamp = DEC_W'(DEC_MAX);
    end

    // Decimation counter, pending/active ratio and warm-up bookkeeping.
    // The result of the wrap that activates a new ratio still closes an
    // old-ratio period; the ORDER results after it are dropped.
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_ratio <= DEC_W'(DEC_MAX);
            r_pend  <= DEC_W'(DEC_MAX);
            r_warm  <= '0;
            r_ev    <= 1'b0;
            r_ek    <= 1'b0;
        end else begin
            r_ev <= w_wrap;
            r_ek <= w_wrap && (r_warm == WARM_DONE);
            if (bus.dec_load) r_pend <= w_clamp;
            if (bus.in_valid) r_cnt <= w_wrap ? '0 : r_cnt + DEC_W'(1);
            if (w_wrap) begin
                r_ratio <= r_pend;
                if (r_pend != r_ratio)       r_warm <= '0;
                else if (r_warm != WARM_DONE) r_warm <= r_warm + 3'd1;
            end
        end
    end

    // Comb stage inputs: stage 0 takes the post-update last integrator.
    always_comb begin
        w_cin_i    = r_cmb_i;
        w_cin_q    = r_cmb_q;
        w_cvin     = '0;
        w_ckin     = '0;
        w_cin_i[0] = r_int_i[ORDER-1];
        w_cin_q[0] = r_int_q[ORDER-1];
        w_cvin[0]  = r_ev;
        w_ckin[0]  = r_ek;
        for (int k = 1; k < ORDER; k++) begin
            w_cin_i[k] = r_cmb_i[k-1];
            w_cin_q[k] = r_cmb_q[k-1];
            w_cvin[k]  = r_cv[k-1];
            w_ckin[k]  = r_ck[k-1];
        end
    end

    // Pipelined combs y = x - x_prev, one register stage each; the keep bit
    // rides along so warm-up results still flow through and fill the delays.
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            r_cv <= '0;
            r_ck <= '0;
            for (int k = 0; k < ORDER; k++) begin
                r_cmb_i[k] <= '0;
                r_cmb_q[k] <= '0;
                r_dly_i[k] <= '0;
                r_dly_q[k] <= '0;
            end
        end else begin
            r_cv <= w_cvin;
            r_ck <= w_ckin;
            for (int k = 0; k < ORDER; k++) begin
                if (w_cvin[k]) begin
                    r_cmb_i[k] <= w_cin_i[k] - r_dly_i[k];
                    r_cmb_q[k] <= w_cin_q[k] - r_dly_q[k];
                    r_dly_i[k] <= w_cin_i[k];
                    r_dly_q[k] <= w_cin_q[k];
                end
            end
        end
    end

    // Gain window: g = min(gain_shift, ACC_W-OUT_W), shift = ACC_W-OUT_W-g.
    always_comb begin
        w_g = (bus.gain_shift > 8'(HEAD)) ? 8'(HEAD) : bus.gain_shift;
        w_sh = HEAD - int'(w_g);
        scale(r_cmb_i[ORDER-1], w_sh, w_o_i, w_sat_i);
        scale(r_cmb_q[ORDER-1], w_sh, w_o_q, w_sat_q);
    end

    assign w_load = r_cv[ORDER-1] && r_ck[ORDER-1];

    // Output holding register, handshake and sticky flags.
    always_ff @(posedge osc_clk) begin
        if (rst) begin
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
            r_dclk      <= 1'b0;
            r_sat       <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_dclk <= w_load;
            if (w_load) begin
                r_out_i     <= w_o_i;
                r_out_q     <= w_o_q;
                r_out_valid <= 1'b1;
                if (r_out_valid && !bus.out_ready) r_overrun <= 1'b1;
                if (w_sat_i || w_sat_q)            r_sat     <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_i        = r_out_i;
    assign bus.out_q        = r_out_q;
    assign bus.out_valid    = r_out_valid;
    assign bus.d_clk        = r_dclk;
    assign bus.sat_flag     = r_sat;
    assign bus.overrun_flag = r_overrun;
endmodule

// File: tb/tb_cic_iq_decimator.sv
// Directed bench for cic_iq_decimator (ORDER=4, ACC_W=80, OUT_W=32).
module tb_cic_iq_decimator;
    localparam int IN_W    = 20;
    localparam int OUT_W   = 32;
    localparam int ORDER   = 4;
    localparam int ACC_W   = 80;
    localparam int DEC_MAX = 4096;
    localparam int DEC_W   = 13;

`ifdef CIC_ROUND_EN
    localparam logic [31:0] RND_EXP = 32'd41;
`else
    localparam logic [31:0] RND_EXP = 32'd40;
`endif

    logic osc_clk;
    logic rst;
    int   total, bad, n_smp;

    cic_iq_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEC_W(DEC_W)) bus ();

    cic_iq_decimator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ORDER(ORDER), .ACC_W(ACC_W),
        .DEC_MAX(DEC_MAX), .DEC_W(DEC_W)
    ) dut (
        .osc_clk (osc_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic took;
        took = bus.in_valid & ~rst;
        @(posedge osc_clk);
        #1;
        if (took) n_smp++;
    endtask

    // Eight ratio-8 samples (the last one wraps), then idle up to the cycle
    // before the output register loads.
    task automatic run_period();
        bus.in_valid = 1'b1;
        repeat (8) step();
        bus.in_valid = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int nv, lat, got, n0, n1, n2;
        logic [31:0] v1, v2, v2q;
        total = 0; bad = 0; n_smp = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0;
        bus.dec_ratio = '0; bus.dec_load = 1'b0;
        bus.gain_shift = 8'd48; bus.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_i", bus.out_i, 32'd0);
        check("rst_out_q", bus.out_q, 32'd0);
        check("rst_d_clk", 32'(bus.d_clk), 32'd0);
        check("rst_sat", 32'(bus.sat_flag), 32'd0);
        check("rst_overrun", 32'(bus.overrun_flag), 32'd0);

        // DC 1, load ratio 8. Active ratio is 4096 until its first wrap
        // (sample 4096), then ratio 8 with four warm-up results dropped:
        // first output comes from the wrap at sample 4136, seen 5 edges later.
        rst = 1'b0; n_smp = 0;
        bus.in_i = 20'sd1; bus.in_q = 20'sd1; bus.in_valid = 1'b1;
        bus.dec_ratio = 13'd8; bus.dec_load = 1'b1;
        step();
        bus.dec_load = 1'b0;
        nv = int'(bus.out_valid);
        while (n_smp < 40) begin
            step();
            if (bus.out_valid) nv++;
        end
        check("warmup_quiet", 32'(nv), 32'd0);
        for (int i = 0; i < 6000 && !bus.out_valid; i++) step();
        check("first_seen", 32'(bus.out_valid), 32'd1);
        check("first_smp", 32'(n_smp), 32'd4141);
        check("first_i", bus.out_i, 32'd4096);
        check("first_q", bus.out_q, 32'd4096);
        check("first_dclk", 32'(bus.d_clk), 32'd1);
        check("first_sat", 32'(bus.sat_flag), 32'd0);
        check("first_overrun", 32'(bus.overrun_flag), 32'd0);
        step();
        check("dclk_one_cycle", 32'(bus.d_clk), 32'd0);
        check("ready_clears", 32'(bus.out_valid), 32'd0);
        step();

        // Latency: isolated wrap sample 4144, result visible after 5 edges.
        bus.in_valid = 1'b0;
        repeat (2) step();
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        check("lat_dclk", 32'(bus.d_clk), 32'd1);
        check("lat_i", bus.out_i, 32'd4096);
        step();

        // Hold, then a new result arriving with out_ready high: no overrun.
        bus.out_ready = 1'b0;
        run_period();
        step();
        check("hold_load", 32'(bus.out_valid), 32'd1);
        check("hold_i", bus.out_i, 32'd4096);
        repeat (3) step();
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_dclk", 32'(bus.d_clk), 32'd0);
        run_period();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("coll_valid", 32'(bus.out_valid), 32'd1);
        check("coll_dclk", 32'(bus.d_clk), 32'd1);
        check("coll_overrun", 32'(bus.overrun_flag), 32'd0);

        // Overwrite while held: gain 47 makes the newer result 2048.
        bus.gain_shift = 8'd47;
        run_period();
        step();
        check("ovr_flag", 32'(bus.overrun_flag), 32'd1);
        check("ovr_valid", 32'(bus.out_valid), 32'd1);
        check("ovr_i", bus.out_i, 32'd2048);
        check("ovr_q", bus.out_q, 32'd2048);
        check("ovr_sat", 32'(bus.sat_flag), 32'd0);

        // Ratio change mid-period: ratio 1 clamps to 2, active at the wrap
        // 5 samples on (that result closes the last ratio-8 period), then
        // four ratio-2 results are dropped and the fifth is 16.
        bus.gain_shift = 8'd48; bus.out_ready = 1'b1;
        step();
        check("chg_consumed", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b0; bus.dec_ratio = 13'd1; bus.dec_load = 1'b1;
        step();
        bus.dec_load = 1'b0;
        n0 = n_smp; got = 0; n1 = 0; n2 = 0; v1 = '0; v2 = '0; v2q = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60 && got < 2; i++) begin
            step();
            if (bus.d_clk) begin
                if (got == 0) begin n1 = n_smp; v1 = bus.out_i; end
                else begin n2 = n_smp; v2 = bus.out_i; v2q = bus.out_q; end
                got++;
            end
        end
        check("chg_count", 32'(got), 32'd2);
        check("chg_old_val", v1, 32'd4096);
        check("chg_old_at", 32'(n1 - n0), 32'd10);
        check("chg_new_at", 32'(n2 - n0), 32'd20);
        check("chg_new_i", v2, 32'd16);
        check("chg_new_q", v2q, 32'd16);

        // Saturation at ratio 4096 with full-scale inputs of both signs.
        rst = 1'b1; bus.in_valid = 1'b0;
        repeat (2) step();
        check("rst2_overrun", 32'(bus.overrun_flag), 32'd0);
        check("rst2_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.in_i = 20'sh7FFFF; bus.in_q = 20'sh80000; bus.in_valid = 1'b1;
        for (int i = 0; i < 21000 && !bus.out_valid; i++) step();
        check("sat_seen", 32'(bus.out_valid), 32'd1);
        check("sat_i", bus.out_i, 32'h7FFF_FFFF);
        check("sat_q", bus.out_q, 32'h8000_0000);
        check("sat_flag", 32'(bus.sat_flag), 32'd1);
        check("sat_overrun", 32'(bus.overrun_flag), 32'd0);

        // Rounding: ratio 3, DC 1, gain 47 -> 81/2 = 40 (41 when rounded).
        rst = 1'b1; bus.in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        bus.in_i = 20'sd1; bus.in_q = 20'sd1; bus.gain_shift = 8'd47;
        bus.dec_ratio = 13'd3; bus.dec_load = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.dec_load = 1'b0;
        for (int i = 0; i < 5000 && !bus.out_valid; i++) step();
        check("rnd_seen", 32'(bus.out_valid), 32'd1);
        check("rnd_i", bus.out_i, RND_EXP);
        check("rnd_q", bus.out_q, RND_EXP);
        check("rnd_sat", 32'(bus.sat_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
